serial_addsub_nbit: RTL

Parametrised bit-serial adder/subtractor. It takes two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first, through a single full add/subtract cell with a registered carry/borrow. It then presents the result with carry/borrow, signed-overflow and zero flags, and pulses done. It is the multi-bit, sequential successor to the team's 1-bit full subtractor, for datapaths where area matters more than latency.

---
 rtl/serial_addsub_nbit.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_addsub_nbit.sv
// serial_addsub_nbit: bit-serial add/subtract, one bit per clock, LSB first.
// A single full add/subtract cell with a registered carry/borrow walks the
// operands. Result and flags are registered and held until the next operation
// completes.
module serial_addsub_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q;
  // Holds the bits produced so far; the newest bit enters at the top.
  logic [WIDTH-2:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             mode_q;

  logic             x, y, d, c_next, last, ovf_next;
  logic [WIDTH-1:0] sum_sr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // Full add/subtract cell on the current operand LSBs.
  always_comb begin
    x      = opa_q[0];
    y      = opb_q[0];
    d      = x ^ y ^ c_q;
    c_next = mode_q ? ((x & y) | ((x ^ y) & c_q))
                    : ((~x & y) | (~(x ^ y) & c_q));
    sum_sr = {d, acc_q};
    last   = (cnt_q == LAST);
    // On the last bit x/y are the operand sign bits, so overflow falls out here.
    ovf_next = mode_q ? ((x == y) && (d != x))
                      : ((x != y) && (d != x));
  end

  // Operand/accumulator shifting and the output load on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      mode_q    <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        opa_q  <= a;
        opb_q  <= b;
        mode_q <= mode;
        acc_q  <= '0;
        cnt_q  <= '0;
        c_q    <= 1'b0;
      end
    end else if (state_q == RUN) begin
      opa_q <= opa_q >> 1;
      opb_q <= opb_q >> 1;
      acc_q <= sum_sr[WIDTH-1:1];
      c_q   <= c_next;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        result    <= sum_sr;
        carry_out <= c_next;
        overflow  <= ovf_next;
        zero      <= (sum_sr == '0);
      end
    end
  end

endmodule
